// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate back end: default widths,
// FSM state encoding, saturation limits and the prefix-adder combine cell.
package mac_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_e;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Group generate/propagate cell: returns {G, P} of the merged span.
  function automatic logic [1:0] gp_combine(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/prefix_add_acc.sv
// Combinational Kogge-Stone adder with zero carry-in; exposes the carry into
// the MSB and the carry out so the caller can detect signed overflow.
module prefix_add_acc
  import mac_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         c_msb_o,
  output logic         c_out_o
);

  localparam int LVL = $clog2(W);

  genvar l;
  generate
    for (l = 0; l <= LVL; l++) begin : g_lvl
      logic [W-1:0] g;
      logic [W-1:0] p;
      if (l == 0) begin : g_base
        assign g = a_i & b_i;
        assign p = a_i ^ b_i;
      end else begin : g_comb
        localparam int D = 1 << (l - 1);
        // One prefix level: merge each bit's span with the span D bits below.
        always_comb begin
          g = '0;
          p = '0;
          for (int i = 0; i < W; i++) begin
            if (i >= D) begin
              {g[i], p[i]} = gp_combine(g_lvl[l-1].g[i], g_lvl[l-1].p[i],
                                        g_lvl[l-1].g[i-D], g_lvl[l-1].p[i-D]);
            end else begin
              g[i] = g_lvl[l-1].g[i];
              p[i] = g_lvl[l-1].p[i];
            end
          end
        end
      end
    end
  endgenerate

  // With cin = 0 the group generate of bits [i:0] is the carry into bit i+1.
  assign sum_o   = g_lvl[0].p ^ {g_lvl[LVL].g[W-2:0], 1'b0};
  assign c_msb_o = g_lvl[LVL].g[W-2];
  assign c_out_o = g_lvl[LVL].g[W-1];

endmodule

// File: rtl/mac_accumulate_stage.sv
// Frame accumulator: sums signed products into a guarded accumulator and
// hands each frame total downstream over a valid/ready handshake.
module mac_accumulate_stage
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             hs_s;
  logic [ACC_W-1:0] base_acc_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic             base_ovf_s;
  logic [ACC_W-1:0] addend_s;
  logic [ACC_W-1:0] sum_s;
  logic             c_msb_s;
  logic             c_out_s;
  logic             add_ovf_s;
  logic [ACC_W-1:0] next_acc_s;
  logic [CNT_W-1:0] next_cnt_s;

  assign hs_s     = in_valid & in_ready_q;
  assign addend_s = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};

  // A clear arriving with a product zeroes the frame before the product is added.
  always_comb begin
    base_acc_s = acc_q;
    base_cnt_s = cnt_q;
    base_ovf_s = ovf_q;
    if (acc_clear) begin
      base_acc_s = '0;
      base_cnt_s = '0;
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_q;
      base_cnt_s = cnt_q;
      base_ovf_s = ovf_q;
    end
  end

  prefix_add_acc #(.W(ACC_W)) u_add (
    .a_i     (base_acc_s),
    .b_i     (addend_s),
    .sum_o   (sum_s),
    .c_msb_o (c_msb_s),
    .c_out_o (c_out_s)
  );

  assign add_ovf_s = c_msb_s ^ c_out_s;

  // On overflow both operands share a sign, so the accumulator sign picks the rail.
  always_comb begin
    next_acc_s = sum_s;
    if (add_ovf_s && SAT_EN) begin
      next_acc_s = base_acc_s[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      next_acc_s = sum_s;
    end
  end

  // Term counter that sticks at its maximum.
  always_comb begin
    next_cnt_s = base_cnt_s;
    if (base_cnt_s == CNT_MAX) begin
      next_cnt_s = CNT_MAX;
    end else begin
      next_cnt_s = base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // FSM next state together with accumulator and result register updates.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE: begin
        state_d = ACCUM;
      end
      ACCUM: begin
        if (hs_s) begin
          acc_d = next_acc_s;
          cnt_d = next_cnt_s;
          ovf_d = base_ovf_s | add_ovf_s;
          if (in_last) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_data_d  = next_acc_s;
            out_count_d = next_cnt_s;
            out_ovf_d   = base_ovf_s | add_ovf_s;
          end else begin
            state_d = ACCUM;
          end
        end else if (acc_clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus and
// are compared against fixed vectors and a plain-arithmetic reference model.
module tb_mac_accumulate_stage;

  localparam longint ACC_MAX_L = (longint'(1) <<< 39) - 1;
  localparam longint ACC_MIN_L = -(longint'(1) <<< 39);
  localparam longint MOD_L     = longint'(1) <<< 40;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, acc_clear, out_ready;
  logic [31:0] in_data;
  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [39:0] out_data_s;
  logic [7:0]  out_count_s;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [39:0] out_data_w;
  logic [7:0]  out_count_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_accumulate_stage #(.SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_count(out_count_s), .out_ovf(out_ovf_s)
  );

  mac_accumulate_stage #(.SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_count(out_count_w), .out_ovf(out_ovf_w)
  );

  typedef struct {
    int     n;
    int     d0;
    int     d1;
    int     d2;
    longint exp_data;
    int     exp_cnt;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ideal signed sum, then either clamp or fold back into 40 bits.
  task automatic ref_add(input longint acc, input longint x, input bit sat,
                         output longint res, output bit ov);
    longint s;
    s  = acc + x;
    ov = 1'b0;
    if (s > ACC_MAX_L) begin
      ov = 1'b1;
      s  = sat ? ACC_MAX_L : s - MOD_L;
    end else if (s < ACC_MIN_L) begin
      ov = 1'b1;
      s  = sat ? ACC_MIN_L : s + MOD_L;
    end
    res = s;
  endtask

  task automatic send(input logic [31:0] x, input bit last, input bit clr);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_data   = x;
    in_last   = last;
    acc_clear = clr;
    while (!in_ready_s && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready_s) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    acc_clear = 1'b0;
  endtask

  task automatic chk_result(input string tag, input longint exp_s, input longint exp_w,
                            input int cnt, input bit ovf_s, input bit ovf_w);
    chk({tag, "_valid_sat"},  longint'(out_valid_s), 1);
    chk({tag, "_valid_wrap"}, longint'(out_valid_w), 1);
    chk({tag, "_data_sat"},   longint'($signed(out_data_s)), exp_s);
    chk({tag, "_data_wrap"},  longint'($signed(out_data_w)), exp_w);
    chk({tag, "_count_sat"},  longint'(out_count_s), longint'(cnt));
    chk({tag, "_count_wrap"}, longint'(out_count_w), longint'(cnt));
    chk({tag, "_ovf_sat"},    longint'(out_ovf_s), longint'(ovf_s));
    chk({tag, "_ovf_wrap"},   longint'(out_ovf_w), longint'(ovf_w));
  endtask

  // Assumes out_ready is high: the result drains at the next edge.
  task automatic chk_release(input string tag);
    @(posedge clk); #1;
    chk({tag, "_rel_valid"},    longint'(out_valid_s), 0);
    chk({tag, "_rel_ready"},    longint'(in_ready_s), 1);
    chk({tag, "_rel_ready_w"},  longint'(in_ready_w), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    longint ms, mw, xs;
    bit     os, ow, ts, tw;
    int     n, x;

    vecs[0] = '{3, 3, -5, 100, 64'sd98, 3, 1'b0};
    vecs[1] = '{1, 7, 0, 0, 64'sd7, 1, 1'b0};
    vecs[2] = '{3, int'(32'h8000_0000), int'(32'h8000_0000), -1, -64'sd4294967297, 3, 1'b0};
    vecs[3] = '{2, 2147483647, 1, 0, 64'sd2147483648, 2, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b1; in_data = '0;
    @(posedge clk); #1;
    chk("rst_in_ready",  longint'(in_ready_s), 0);
    chk("rst_out_valid", longint'(out_valid_s), 0);
    chk("rst_out_data",  longint'(out_data_s), 0);
    chk("rst_out_count", longint'(out_count_s), 0);
    chk("rst_out_ovf",   longint'(out_ovf_w), 0);
    rst = 1'b0;
    chk("idle_in_ready", longint'(in_ready_s), 0);
    @(posedge clk); #1;
    chk("accum_in_ready", longint'(in_ready_s), 1);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        x = (k == 0) ? vecs[v].d0 : (k == 1) ? vecs[v].d1 : vecs[v].d2;
        send(x, k == vecs[v].n - 1, 1'b0);
      end
      chk_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_data,
                 vecs[v].exp_cnt, vecs[v].exp_ovf, vecs[v].exp_ovf);
      chk_release($sformatf("vec%0d", v));
    end

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 8);
      ms = 0; mw = 0; os = 1'b0; ow = 1'b0;
      for (int k = 0; k < n; k++) begin
        x  = int'($urandom);
        xs = longint'(x);
        ref_add(ms, xs, 1'b1, ms, ts);
        ref_add(mw, xs, 1'b0, mw, tw);
        os = os | ts;
        ow = ow | tw;
        send(x, k == n - 1, 1'b0);
      end
      chk_result($sformatf("rnd%0d", f), ms, mw, n, os, ow);
      chk_release($sformatf("rnd%0d", f));
    end

    out_ready = 1'b0;
    send(32'd7, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd0;
    for (int c = 0; c < 5; c++) begin
      acc_clear = (c >= 3);
      chk($sformatf("bp%0d_valid", c), longint'(out_valid_s), 1);
      chk($sformatf("bp%0d_data", c),  longint'($signed(out_data_w)), 7);
      chk($sformatf("bp%0d_ready", c), longint'(in_ready_s), 0);
      @(posedge clk); #1;
    end
    acc_clear = 1'b0;
    chk_result("bp_hold_clear", 7, 7, 1, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_rel_valid", longint'(out_valid_s), 0);
    chk("bp_rel_ready", longint'(in_ready_s), 1);

    for (int k = 0; k < 300; k++) begin
      send(32'h7FFF_FFFF, k == 299, 1'b0);
    end
    chk_result("sat300", ACC_MAX_L, -64'sd455266533676, 255, 1'b1, 1'b1);
    chk_release("sat300");

    send(32'd10, 1'b0, 1'b0);
    send(32'd20, 1'b0, 1'b0);
    send(-32'sd4, 1'b1, 1'b1);
    chk_result("clr_hs", -4, -4, 1, 1'b0, 1'b0);
    chk_release("clr_hs");

    send(32'd5, 1'b0, 1'b0);
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    send(32'd6, 1'b1, 1'b0);
    chk_result("clr_idle_cyc", 6, 6, 1, 1'b0, 1'b0);
    chk_release("clr_idle_cyc");

    out_ready = 1'b0;
    send(32'd50, 1'b1, 1'b0);
    chk("mrst_pre_valid", longint'(out_valid_s), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid_sat",  longint'(out_valid_s), 0);
    chk("mrst_valid_wrap", longint'(out_valid_w), 0);
    out_ready = 1'b1;
    send(32'd9, 1'b1, 1'b0);
    chk_result("mrst_next", 9, 9, 1, 1'b0, 1'b0);
    chk_release("mrst_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_accumulate_stage.md
Name: mac_accumulate_stage

Overview:
- Sequential accumulate back end of the 16-bit MAC. Consumes signed 32-bit products from the multiplier over a valid/ready handshake.
- Sums each frame into a 40-bit accumulator with 8 guard bits. The sum is formed by a parallel-prefix (Kogge-Stone) adder built from group generate/propagate cells.
- Presents the frame result downstream over a second valid/ready handshake when the last product of the frame arrives.

Parameters:
- PROD_W, 32, product width (signed two's complement).
- ACC_W, 40, accumulator and result width. Must be ≥ PROD_W+1.
- CNT_W, 8, width of the term counter.
- SAT_EN, 1, 1 = clamp on signed overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  product present.
- in_ready  out  1  block can accept a product.
- in_data  in  PROD_W  signed product.
- in_last  in  1  marks the last product of the frame; qualified by in_valid.
- acc_clear  in  1  discards the running sum of the current frame.
- out_valid  out  1  frame result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed frame sum.
- out_count  out  CNT_W  number of products in the frame.
- out_ovf  out  1  sticky: saturation or wrap occurred in the frame.

Behaviour:
- Reset: one clock, synchronous, active-high. Sampled on the rising clk edge and overrides all other inputs.
- Reset values:
  - state = IDLE
  - acc = 0, count = 0, ovf = 0
  - in_ready = 0
  - out_valid = 0, out_data = 0, out_count = 0, out_ovf = 0
- States:
  - IDLE → ACCUM unconditionally on the next clock. in_ready = 0 for exactly the first cycle after reset.
  - ACCUM: in_ready = 1, out_valid = 0. An input handshake (in_valid & in_ready) performs:
    - acc ← acc + sext(in_data)
    - count ← count + 1, saturating at 2^CNT_W − 1
    - ovf |= overflow
  - ACCUM → HOLD on an input handshake with in_last = 1. At the same edge, out_data/out_count/out_ovf load the updated acc/count/ovf and out_valid ← 1. Latency from the last-product handshake to out_valid is 1 cycle.
  - HOLD: in_ready = 0 and the outputs are stable. When out_valid & out_ready: out_valid ← 0, acc/count/ovf ← 0, state → ACCUM.
- Overflow: signed overflow of the ACC_W addition, i.e. both operand signs equal and the sum sign differs.
  - SAT_EN = 1: acc clamps to +(2^(ACC_W−1) − 1) or −2^(ACC_W−1), and ovf is set.
  - SAT_EN = 0: the sum wraps and ovf is still set.
- acc_clear in ACCUM without a handshake: acc/count/ovf ← 0.
- acc_clear together with a handshake in the same cycle: the clear applies first, so acc ← sext(in_data), count ← 1, and ovf ← 0 unless this addition overflows. If in_last = 1, the result is emitted as normal.
- acc_clear in IDLE or HOLD: ignored; the held result is unaffected.
- in_last without in_valid: ignored.
- A single-product frame (in_last on the first term) is legal: out_count = 1 and out_data = sext(in_data).
- rst during HOLD: the pending result is dropped and out_valid falls at that edge.
- Adder: purely combinational within one cycle.
  - Bitwise g = a&b, p = a^b.
  - log2(ACC_W) prefix levels, 6 levels for 40 bits. Each level combines G = Gi | (Pi & Gprev) and P = Pi & Pprev.
  - sum = p ^ {carries, cin = 0}.
  - Register-to-register path: acc → adder → acc.

Decomposition:
- Shared package mac_pkg:
  - ACC_W, PROD_W, CNT_W defaults.
  - State encoding IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2.
  - ACC_MAX and ACC_MIN constants.
- Sub-module prefix_add_acc: combinational ACC_W Kogge-Stone adder built from the existing group generate/propagate cells.
  - Inputs: a, b.
  - Outputs: sum, and the carry into the MSB plus the carry out, for overflow detection.
- The FSM, counter, saturation and output registers live in mac_accumulate_stage.

Test Plan:
- Reset then a frame of 3, −5, 100 (last on 100), out_ready = 1 → in_ready = 0 in the first post-reset cycle. out_valid rises 1 cycle after the last handshake with out_data = 98, out_count = 3, out_ovf = 0. After the result handshake, in_ready = 1 and the next frame starts from 0.
- Backpressure: frame of 7 (last), out_ready = 0 for 5 cycles → out_valid stays 1, out_data = 7 stable, and in_ready = 0 with in_valid held high. The result is released and in_ready rises the cycle after out_ready = 1.
- Saturation, SAT_EN = 1: 300 products of 0x7FFFFFFF → out_data = 2^39 − 1, out_ovf = 1, out_count = 255 (saturated).
- Wrap, SAT_EN = 0: the same stimulus → out_data = (300 × (2^31 − 1)) mod 2^40 as signed, out_ovf = 1.
- acc_clear coinciding with a handshake: after 10 and 20, assert acc_clear with product −4 and in_last → out_data = −4, out_count = 1. In a separate run, acc_clear during HOLD leaves the result unchanged.
- Mid-frame reset: accept 50, hit the HOLD state, assert rst for 1 cycle → out_valid = 0 at the edge. A following frame of 9 (last) → out_data = 9, out_count = 1, out_ovf = 0.
